// File: rtl/butterfly.sv
// Radix-2 DIT FFT butterfly: X = A + B*W, Y = A - B*W.
// Three-stage pipeline, Q8.8 data, Q2.14 twiddle, saturating outputs.
module butterfly (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] Ar,
    input  logic signed [15:0] Ai,
    input  logic signed [15:0] Br,
    input  logic signed [15:0] Bi,
    input  logic signed [15:0] Wr,
    input  logic signed [15:0] Wi,
    output logic signed [15:0] Xr_F,
    output logic signed [15:0] Xi_F,
    output logic signed [15:0] Yr_F,
    output logic signed [15:0] Yi_F
);

    // Stage 1: input registers
    logic signed [15:0] ar_q, ai_q, br_q, bi_q, wr_q, wi_q;
    // Stage 2: partial products (Q10.22) and A delayed one stage
    logic signed [31:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [15:0] ar_d_q, ai_d_q;

    // Stage 3 combinational signals
    logic signed [32:0] pr_full, pi_full;
    logic signed [20:0] pr_t, pi_t;
    logic signed [20:0] xr_sum, xi_sum, yr_sum, yi_sum;

    function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
        if (v > 21'sd32767) begin
            return 16'sh7fff;
        end else if (v < -21'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            bi_q <= '0;
            wr_q <= '0;
            wi_q <= '0;
        end else begin
            ar_q <= Ar;
            ai_q <= Ai;
            br_q <= Br;
            bi_q <= Bi;
            wr_q <= Wr;
            wi_q <= Wi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            ar_d_q <= '0;
            ai_d_q <= '0;
        end else begin
            p_rr_q <= 32'(br_q) * 32'(wr_q);
            p_ii_q <= 32'(bi_q) * 32'(wi_q);
            p_ri_q <= 32'(br_q) * 32'(wi_q);
            p_ir_q <= 32'(bi_q) * 32'(wr_q);
            ar_d_q <= ar_q;
            ai_d_q <= ai_q;
        end
    end

    // After >>>14 the product fits in 19 bits, so 21-bit add/sub cannot overflow
    always_comb begin
        pr_full = 33'(p_rr_q) - 33'(p_ii_q);
        pi_full = 33'(p_ri_q) + 33'(p_ir_q);
        pr_t    = 21'(pr_full >>> 14);
        pi_t    = 21'(pi_full >>> 14);
        xr_sum  = 21'(ar_d_q) + pr_t;
        xi_sum  = 21'(ai_d_q) + pi_t;
        yr_sum  = 21'(ar_d_q) - pr_t;
        yi_sum  = 21'(ai_d_q) - pi_t;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Xr_F <= '0;
            Xi_F <= '0;
            Yr_F <= '0;
            Yi_F <= '0;
        end else begin
            Xr_F <= sat16(xr_sum);
            Xi_F <= sat16(xi_sum);
            Yr_F <= sat16(yr_sum);
            Yi_F <= sat16(yi_sum);
        end
    end

endmodule

// File: tb/tb_butterfly.sv
// Directed bench for butterfly: hand-computed vectors, streaming against a
// floor-division reference, and mid-stream reset.
module tb_butterfly;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] Ar, Ai, Br, Bi, Wr, Wi;
    logic        [15:0] Xr_F, Xi_F, Yr_F, Yi_F;

    int checks = 0;
    int errors = 0;

    logic [15:0] sv [8][6] = '{
        '{16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'h4000, 16'h0000},
        '{16'hFE80, 16'h0040, 16'h0123, 16'h0456, 16'h2D41, 16'hD2BF},
        '{16'h1234, 16'hEDCC, 16'h0800, 16'hF800, 16'h0000, 16'hC000},
        '{16'h7000, 16'h7000, 16'h2000, 16'h2000, 16'h4000, 16'h4000},
        '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000},
        '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h3FFF, 16'hC001},
        '{16'h0A0A, 16'h0505, 16'h0333, 16'h0666, 16'h3B21, 16'h187E},
        '{16'hFFFF, 16'h0000, 16'h0003, 16'hFFFD, 16'h1000, 16'h1000}
    };

    butterfly dut (
        .clk  (clk),
        .reset(reset),
        .Ar   (Ar),
        .Ai   (Ai),
        .Br   (Br),
        .Bi   (Bi),
        .Wr   (Wr),
        .Wi   (Wi),
        .Xr_F (Xr_F),
        .Xi_F (Xi_F),
        .Yr_F (Yr_F),
        .Yi_F (Yi_F)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] xr, input logic [15:0] xi,
                             input logic [15:0] yr, input logic [15:0] yi);
        check_val({tag, "_xr"}, Xr_F, xr);
        check_val({tag, "_xi"}, Xi_F, xi);
        check_val({tag, "_yr"}, Yr_F, yr);
        check_val({tag, "_yi"}, Yi_F, yi);
    endtask

    task automatic drive(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                         input logic [15:0] bi, input logic [15:0] wr, input logic [15:0] wi);
        Ar = ar;
        Ai = ai;
        Br = br;
        Bi = bi;
        Wr = wr;
        Wi = wi;
    endtask

    task automatic drive_sv(input int k);
        drive(sv[k][0], sv[k][1], sv[k][2], sv[k][3], sv[k][4], sv[k][5]);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic longint floor14(input longint p);
        if (p >= 0) return p / 16384;
        return -((-p + 16383) / 16384);
    endfunction

    function automatic logic [15:0] sat_ref(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    // Reference for one vector of the streaming table
    task automatic check_model(input string tag, input int k);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        ar = longint'($signed(sv[k][0]));
        ai = longint'($signed(sv[k][1]));
        br = longint'($signed(sv[k][2]));
        bi = longint'($signed(sv[k][3]));
        wr = longint'($signed(sv[k][4]));
        wi = longint'($signed(sv[k][5]));
        pr = floor14(br * wr - bi * wi);
        pi = floor14(br * wi + bi * wr);
        check_out(tag, sat_ref(ar + pr), sat_ref(ai + pi), sat_ref(ar - pr), sat_ref(ai - pi));
    endtask

    initial begin
        reset = 1'b1;
        drive(16'h0280, 16'h0540, 16'h0600, 16'h0180, 16'h4000, 16'h1800);
        tick();
        tick();
        check_out("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Directed vectors back to back; nominal emerges three edges later
        reset = 1'b0;
        tick();
        check_out("pre1", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive(16'h0100, 16'h0000, 16'h0080, 16'hFFC0, 16'h4000, 16'h0000);
        tick();
        check_out("pre2", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive(16'h7F00, 16'h8100, 16'h7F00, 16'h7F00, 16'h4000, 16'h0000);
        tick();
        check_out("nominal", 16'h07F0, 16'h0900, 16'hFD10, 16'h0180);
        drive(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h2000, 16'h0000);
        tick();
        check_out("trivial", 16'h0180, 16'hFFC0, 16'h0080, 16'h0040);
        drive(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h2000, 16'h0000);
        tick();
        check_out("sat", 16'h7FFF, 16'h0000, 16'h0000, 16'h8000);
        tick();
        check_out("trunc_neg", 16'hFFFF, 16'h0000, 16'h0001, 16'h0000);
        tick();
        check_out("trunc_pos", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Streaming: one new vector per cycle, no bubbles
        for (int c = 0; c < 11; c++) begin
            if (c >= 3) check_model($sformatf("stream%0d", c - 3), c - 3);
            if (c < 8) drive_sv(c);
            else drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
            tick();
        end

        // Mid-stream reset: sv0..sv2 are in flight and must be lost
        drive_sv(0);
        tick();
        drive_sv(1);
        tick();
        drive_sv(2);
        reset = 1'b1;
        tick();
        check_out("rst_hit", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b0;
        drive_sv(3);
        tick();
        check_out("rst_flush1", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive_sv(4);
        tick();
        check_out("rst_flush2", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive_sv(5);
        tick();
        check_model("rst_first", 3);
        tick();
        check_model("rst_second", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
